// File: rtl/hex_display_mux.sv
// rtl/hex_display_mux.sv - time-multiplexed hex seven-segment driver with tear-free load, LZ blanking and blink
module hex_display_mux #(
    parameter int DIGITS           = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int BLINK_FRAMES     = 64,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  en,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIGITS-1:0] AN_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         fcnt;
    logic                  phase;
    logic [4*DIGITS-1:0]   pending;
    logic [4*DIGITS-1:0]   active;
    logic                  wrap_d;

    logic                  tick;
    logic                  wrap;
    logic [3:0]            nib;
    logic                  cur_lz;
    logic                  cur_blink;
    logic [DIGITS-1:0]     lz_blank;
    logic [DIGITS-1:0]     an_sel;
    logic                  zero_run;
    logic                  blank;
    logic [6:0]            seg_next;
    logic [DIGITS-1:0]     an_next;

    function automatic logic [6:0] decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

    assign tick = (pcnt == PW'(REFRESH_DIV - 1));
    assign wrap = tick && (idx == IW'(DIGITS - 1));

    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (active[4*i +: 4] == 4'h0);
            if (i != 0) begin
                lz_blank[i] = zero_run;
            end
        end
    end

    always_comb begin
        nib       = 4'h0;
        cur_lz    = 1'b0;
        cur_blink = 1'b0;
        an_sel    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = active[4*i +: 4];
                cur_lz    = lz_blank[i];
                cur_blink = blink_mask[i];
                an_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        blank    = (blank_lz && cur_lz) || (phase && cur_blink);
        seg_next = (!en || blank) ? SEG_OFF : decode(nib);
        an_next  = en ? an_sel : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end
        end
    end

    // Active only changes at the frame boundary so a scan never mixes two values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            active  <= '0;
        end else begin
            if (load) begin
                pending <= value;
            end
            if (wrap) begin
                active <= load ? value : pending;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // frame_done is delayed twice so it lines up with digit 0 of the new frame on the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            wrap_d     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next;
            an         <= (ANODE_ACTIVE_LOW != 0) ? ~an_next : an_next;
            wrap_d     <= wrap;
            frame_done <= wrap_d;
        end
    end

endmodule

// File: tb/tb_hex_display_mux.sv
// tb/tb_hex_display_mux.sv - directed self-checking bench for hex_display_mux
module tb_hex_display_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic        en;
    logic        blank_lz;
    logic [3:0]  blink_mask;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int vectors;
    int miscompares;

    hex_display_mux #(
        .DIGITS(4),
        .REFRESH_DIV(4),
        .BLINK_FRAMES(2),
        .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .value(value),
        .load(load),
        .en(en),
        .blank_lz(blank_lz),
        .blink_mask(blink_mask),
        .seg(seg),
        .an(an),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for the next frame_done, then records one sample of each digit over the frame.
    task automatic run_frame(input int load_at, input logic [15:0] lv, output logic [27:0] segs);
        int n;
        logic [3:0] ea;
        n = 0;
        do begin
            @(negedge clk);
            load = 1'b0;
            n++;
        end while (!frame_done && n < 40);
        vectors++;
        if (!frame_done) begin
            $display("FAIL frame_sync: frame_done not seen within %0d cycles", n);
            miscompares++;
        end
        segs = '0;
        for (int j = 0; j < 16; j++) begin
            if (j > 0) @(negedge clk);
            if (j % 4 == 1) begin
                segs[(j/4)*7 +: 7] = seg;
                ea = 4'b0001 << (j/4);
                ea = ~ea;
                vectors++;
                if (an !== ea) begin
                    $display("FAIL frame_an: digit %0d an=%b expected %b", j/4, an, ea);
                    miscompares++;
                end
            end
            if (j == load_at) begin
                load  = 1'b1;
                value = lv;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        load = 1'b1;
        value = 16'hFFFF;
        en = 1'b1;
        blank_lz = 1'b0;
        blink_mask = 4'b0000;
        repeat (3) @(negedge clk);
        vectors++;
        if (seg !== 7'h7F || an !== 4'b1111 || frame_done !== 1'b0) begin
            $display("FAIL reset_state: seg=%h an=%b fd=%b expected 7f 1111 0", seg, an, frame_done);
            miscompares++;
        end
        rst_n = 1'b1;
        load = 1'b0;
    endtask

    task automatic test_scan;
        logic [3:0] ea;
        logic       efd;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            ea = 4'b0001 << (((k - 1) / 4) % 4);
            ea = ~ea;
            efd = (k == 17 || k == 33);
            vectors++;
            if (an !== ea || seg !== 7'h01 || frame_done !== efd) begin
                $display("FAIL scan k=%0d: an=%b seg=%h fd=%b expected %b 01 %b", k, an, seg, frame_done, ea, efd);
                miscompares++;
            end
        end
    endtask

    task automatic test_tear_free;
        logic [27:0] s;
        logic [27:0] e;
        run_frame(5, 16'h12AF, s);
        e = {7'h01, 7'h01, 7'h01, 7'h01};
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (s[d*7 +: 7] !== e[d*7 +: 7]) begin
                $display("FAIL tear_cur d%0d: seg=%h expected %h", d, s[d*7 +: 7], e[d*7 +: 7]);
                miscompares++;
            end
        end
        run_frame(-1, 16'h0, s);
        e = {7'h4F, 7'h12, 7'h08, 7'h38};
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (s[d*7 +: 7] !== e[d*7 +: 7]) begin
                $display("FAIL tear_next d%0d: seg=%h expected %h", d, s[d*7 +: 7], e[d*7 +: 7]);
                miscompares++;
            end
        end
    endtask

    task automatic test_coincident;
        logic [27:0] s;
        logic [27:0] e;
        run_frame(14, 16'hBEEF, s);
        run_frame(15, 16'h1234, s);
        e = {7'h60, 7'h30, 7'h30, 7'h38};
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (s[d*7 +: 7] !== e[d*7 +: 7]) begin
                $display("FAIL coincident d%0d: seg=%h expected %h", d, s[d*7 +: 7], e[d*7 +: 7]);
                miscompares++;
            end
        end
        run_frame(-1, 16'h0, s);
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (s[d*7 +: 7] !== e[d*7 +: 7]) begin
                $display("FAIL late_load_wait d%0d: seg=%h expected %h", d, s[d*7 +: 7], e[d*7 +: 7]);
                miscompares++;
            end
        end
        run_frame(-1, 16'h0, s);
        e = {7'h4F, 7'h12, 7'h06, 7'h4C};
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (s[d*7 +: 7] !== e[d*7 +: 7]) begin
                $display("FAIL late_load_show d%0d: seg=%h expected %h", d, s[d*7 +: 7], e[d*7 +: 7]);
                miscompares++;
            end
        end
    endtask

    task automatic test_leading_zeros;
        logic [27:0] s;
        logic [83:0] e;
        logic [47:0] lv;
        blank_lz = 1'b1;
        run_frame(5, 16'h0070, s);
        lv = {16'h0000, 16'h8000, 16'h0000};
        e  = {7'h7F, 7'h7F, 7'h0F, 7'h01,
              7'h7F, 7'h7F, 7'h7F, 7'h01,
              7'h00, 7'h01, 7'h01, 7'h01};
        for (int f = 0; f < 3; f++) begin
            run_frame(f < 2 ? 5 : -1, lv[(2-f)*16 +: 16], s);
            for (int d = 0; d < 4; d++) begin
                vectors++;
                if (s[d*7 +: 7] !== e[(2-f)*28 + d*7 +: 7]) begin
                    $display("FAIL lz f%0d d%0d: seg=%h expected %h", f, d, s[d*7 +: 7], e[(2-f)*28 + d*7 +: 7]);
                    miscompares++;
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_en;
        @(negedge clk);
        vectors++;
        if (frame_done !== 1'b1) begin
            $display("FAIL en_align: fd=%b expected 1", frame_done);
            miscompares++;
        end
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        vectors++;
        if (seg !== 7'h7F || an !== 4'b1111) begin
            $display("FAIL en_off: seg=%h an=%b expected 7f 1111", seg, an);
            miscompares++;
        end
        repeat (13) @(negedge clk);
        vectors++;
        if (frame_done !== 1'b1 || an !== 4'b1111) begin
            $display("FAIL en_cadence: fd=%b an=%b expected 1 1111", frame_done, an);
            miscompares++;
        end
        en = 1'b1;
        @(negedge clk);
        vectors++;
        if (seg !== 7'h01 || an !== 4'b1110) begin
            $display("FAIL en_on: seg=%h an=%b expected 01 1110", seg, an);
            miscompares++;
        end
    endtask

    task automatic test_reset_midop;
        logic [27:0] s;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        load = 1'b1;
        value = 16'hFFFF;
        #1;
        vectors++;
        if (seg !== 7'h7F || an !== 4'b1111 || frame_done !== 1'b0) begin
            $display("FAIL reset_midop: seg=%h an=%b fd=%b expected 7f 1111 0", seg, an, frame_done);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        load = 1'b0;
        run_frame(-1, 16'h0, s);
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (s[d*7 +: 7] !== 7'h01) begin
                $display("FAIL reset_cleared d%0d: seg=%h expected 01", d, s[d*7 +: 7]);
                miscompares++;
            end
        end
    endtask

    task automatic test_blink;
        logic [27:0] s;
        logic [27:0] e0;
        @(negedge clk);
        rst_n = 1'b0;
        blink_mask = 4'b0001;
        @(negedge clk);
        rst_n = 1'b1;
        load = 1'b1;
        value = 16'h0005;
        e0 = {7'h24, 7'h7F, 7'h7F, 7'h24};
        for (int f = 0; f < 4; f++) begin
            run_frame(-1, 16'h0, s);
            vectors++;
            if (s[6:0] !== e0[(3-f)*7 +: 7]) begin
                $display("FAIL blink f%0d d0: seg=%h expected %h", f, s[6:0], e0[(3-f)*7 +: 7]);
                miscompares++;
            end
            vectors++;
            if (s[27:7] !== {7'h01, 7'h01, 7'h01}) begin
                $display("FAIL blink f%0d others: seg=%h expected 010101", f, s[27:7]);
                miscompares++;
            end
        end
        blink_mask = 4'b0000;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset;
        test_scan;
        test_tear_free;
        test_coincident;
        test_leading_zeros;
        test_en;
        test_reset_midop;
        test_blink;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
